// File: rtl/prog_load_sequencer.sv
// Program-load sequencer: parses A5/count/data[/chk] byte frames into instruction-memory writes
// and holds the CPU in reset around the load. Optional checksum byte: `define PLOAD_CHECKSUM_EN.
module prog_load_sequencer #(
    parameter int MAX_WORDS   = 256,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int HOLD_CYC    = 4
)(
    input  logic        clk,
    input  logic        pc_reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] bluetooth_addr,
    output logic [15:0] bluetooth_data,
    output logic        prog_ld,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0]   MAXW      = 16'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO,
`ifdef PLOAD_CHECKSUM_EN
        S_CHECK,
`endif
        S_ERROR, S_RELEASE
    } state_t;

    state_t          r_state;
    logic [HW-1:0]   r_hold_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [15:0]     r_addr;
    logic [15:0]     r_data;
    logic            r_prog_ld;
    logic            r_cpu_hold;
    logic            r_load_done;
    logic            r_load_error;
    logic [15:0]     r_words;
    logic [7:0]      r_cnt_hi;
    logic [15:0]     r_count;
    logic [7:0]      r_data_hi;
`ifdef PLOAD_CHECKSUM_EN
    logic [7:0]      r_chk;
`endif

    logic            w_header;
    logic [15:0]     w_cnt;
    logic            w_last_word;

    assign w_header    = rx_valid && (rx_data == 8'hA5);
    assign w_cnt       = {r_cnt_hi, rx_data};
    assign w_last_word = (r_words + 16'd1) == r_count;

    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            r_state      <= S_RELEASE;
            r_hold_cnt   <= '0;
            r_to_cnt     <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_prog_ld    <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_words      <= '0;
            r_cnt_hi     <= '0;
            r_count      <= '0;
            r_data_hi    <= '0;
`ifdef PLOAD_CHECKSUM_EN
            r_chk        <= '0;
`endif
        end else begin
            r_prog_ld   <= 1'b0;
            r_load_done <= 1'b0;
            // Address/count advance in the cycle after each write strobe.
            if (r_prog_ld) begin
                r_addr  <= r_addr + 16'd1;
                r_words <= r_words + 16'd1;
            end
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (w_header) begin
                        r_state      <= S_CNT_HI;
                        r_cpu_hold   <= 1'b1;
                        r_addr       <= '0;
                        r_words      <= '0;
                        r_load_error <= 1'b0;
                        r_to_cnt     <= '0;
`ifdef PLOAD_CHECKSUM_EN
                        r_chk        <= '0;
`endif
                    end
                end
                S_RELEASE: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt  <= '0;
                        r_cpu_hold  <= 1'b0;
                        r_load_done <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    // In-frame states: an arriving byte beats a same-cycle timeout.
                    if (rx_valid) begin
                        r_to_cnt <= '0;
                        case (r_state)
                            S_CNT_HI: begin
                                r_cnt_hi <= rx_data;
                                r_state  <= S_CNT_LO;
                            end
                            S_CNT_LO: begin
                                r_count <= w_cnt;
                                if (w_cnt == 16'd0 || w_cnt > MAXW) begin
                                    r_state      <= S_ERROR;
                                    r_load_error <= 1'b1;
                                end else begin
                                    r_state <= S_DATA_HI;
                                end
                            end
                            S_DATA_HI: begin
                                r_data_hi <= rx_data;
                                r_state   <= S_DATA_LO;
`ifdef PLOAD_CHECKSUM_EN
                                r_chk     <= r_chk ^ rx_data;
`endif
                            end
                            S_DATA_LO: begin
                                r_data    <= {r_data_hi, rx_data};
                                r_prog_ld <= 1'b1;
`ifdef PLOAD_CHECKSUM_EN
                                r_chk     <= r_chk ^ rx_data;
                                r_state   <= w_last_word ? S_CHECK : S_DATA_HI;
`else
                                r_hold_cnt <= '0;
                                r_state    <= w_last_word ? S_RELEASE : S_DATA_HI;
`endif
                            end
`ifdef PLOAD_CHECKSUM_EN
                            S_CHECK: begin
                                if (rx_data == r_chk) begin
                                    r_hold_cnt <= '0;
                                    r_state    <= S_RELEASE;
                                end else begin
                                    r_state      <= S_ERROR;
                                    r_load_error <= 1'b1;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state      <= S_ERROR;
                        r_load_error <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bluetooth_addr = r_addr;
    assign bluetooth_data = r_data;
    assign prog_ld        = r_prog_ld;
    assign cpu_hold       = r_cpu_hold;
    assign load_done      = r_load_done;
    assign load_error     = r_load_error;
    assign words_loaded   = r_words;

endmodule
